// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared widths, state encodings and the grant-selection helper
//               for the instruction-fetch / data-memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  localparam int c_ADDR_W = 32;   // address bus width
  localparam int c_DATA_W = 32;   // data / instruction bus width
  localparam int c_SEL_W  = 4;    // byte-enable width
  localparam int c_WAIT_W = 8;    // wait-cycle counter width

  // Fetches always read a full word.
  localparam logic [c_SEL_W-1:0] c_SEL_ALL = '1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_XFER = 2'd1,
    ARB_DM_XFER = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_t;

  // Single requester wins outright; on a tie the port that was not granted
  // last time goes next, so neither port can be starved.
  function automatic grant_t pick_grant(input logic   if_req,
                                        input logic   dm_req,
                                        input grant_t last_grant);
    grant_t g;
    if (if_req && dm_req) begin
      if (last_grant == GRANT_IF) g = GRANT_DM;
      else                        g = GRANT_IF;
    end else if (dm_req) begin
      g = GRANT_DM;
    end else begin
      g = GRANT_IF;
    end
    return g;
  endfunction

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Arbitrates one shared memory bus between an instruction-fetch
//               port and a data-memory port. One transfer at a time,
//               alternating priority on simultaneous requests, with a
//               wait-cycle timeout that aborts a stuck transfer.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   if_req/if_addr              : fetch request and address
//   if_rdata/if_ack             : fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_sel/
//   dm_addr/dm_wdata            : data request and qualifiers
//   dm_rdata/dm_ack             : read data, one-cycle completion pulse
//   bus_req/bus_we/bus_sel/
//   bus_addr/bus_wdata          : registered shared-bus request
//   bus_rdata/bus_ready         : memory read data and completion strobe
//   stall_if/stall_mem          : pipeline stall requests (combinational)
//   bus_err                     : one-cycle timeout pulse, coincident with ack
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255   // legal range 1..255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction-fetch port
  input  logic                if_req,
  input  logic [c_ADDR_W-1:0] if_addr,
  output logic [c_DATA_W-1:0] if_rdata,
  output logic                if_ack,
  // data-memory port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [c_SEL_W-1:0]  dm_sel,
  input  logic [c_ADDR_W-1:0] dm_addr,
  input  logic [c_DATA_W-1:0] dm_wdata,
  output logic [c_DATA_W-1:0] dm_rdata,
  output logic                dm_ack,
  // shared memory bus
  output logic                bus_req,
  output logic                bus_we,
  output logic [c_SEL_W-1:0]  bus_sel,
  output logic [c_ADDR_W-1:0] bus_addr,
  output logic [c_DATA_W-1:0] bus_wdata,
  input  logic [c_DATA_W-1:0] bus_rdata,
  input  logic                bus_ready,
  // pipeline control
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  // The counter value seen during the last permitted wait cycle; a not-ready
  // cycle at this value is the one that takes the counter to the limit.
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  arb_state_t           r_state;
  grant_t               r_last_grant;
  logic [c_WAIT_W-1:0]  r_wait_cnt;
  logic                 r_bus_req;
  logic                 r_bus_we;
  logic [c_SEL_W-1:0]   r_bus_sel;
  logic [c_ADDR_W-1:0]  r_bus_addr;
  logic [c_DATA_W-1:0]  r_bus_wdata;
  logic [c_DATA_W-1:0]  r_if_rdata;
  logic [c_DATA_W-1:0]  r_dm_rdata;
  logic                 r_if_ack;
  logic                 r_dm_ack;
  logic                 r_bus_err;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  arb_state_t           w_state;
  grant_t               w_last_grant;
  grant_t               w_grant;
  logic [c_WAIT_W-1:0]  w_wait_cnt;
  logic                 w_bus_req;
  logic                 w_bus_we;
  logic [c_SEL_W-1:0]   w_bus_sel;
  logic [c_ADDR_W-1:0]  w_bus_addr;
  logic [c_DATA_W-1:0]  w_bus_wdata;
  logic [c_DATA_W-1:0]  w_if_rdata;
  logic [c_DATA_W-1:0]  w_dm_rdata;
  logic                 w_if_ack;
  logic                 w_dm_ack;
  logic                 w_bus_err;
  logic                 w_finish;      // transfer ends this cycle
  logic [c_DATA_W-1:0]  w_resp_data;   // data handed back to the requester

  always_comb begin
    // Hold everything by default; acks and the error pulse default low so
    // they last exactly one cycle.
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_grant      = pick_grant(if_req, dm_req, r_last_grant);
    w_wait_cnt   = r_wait_cnt;
    w_bus_req    = r_bus_req;
    w_bus_we     = r_bus_we;
    w_bus_sel    = r_bus_sel;
    w_bus_addr   = r_bus_addr;
    w_bus_wdata  = r_bus_wdata;
    w_if_rdata   = r_if_rdata;
    w_dm_rdata   = r_dm_rdata;
    w_if_ack     = 1'b0;
    w_dm_ack     = 1'b0;
    w_bus_err    = 1'b0;
    w_finish     = 1'b0;
    w_resp_data  = '0;

    case (r_state)
      ARB_IDLE: begin
        if (if_req || dm_req) begin
          w_last_grant = w_grant;
          w_wait_cnt   = '0;
          w_bus_req    = 1'b1;
          if (w_grant == GRANT_DM) begin
            w_state     = ARB_DM_XFER;
            w_bus_we    = dm_we;
            w_bus_sel   = dm_sel;
            w_bus_addr  = dm_addr;
            w_bus_wdata = dm_wdata;
          end else begin
            w_state     = ARB_IF_XFER;
            w_bus_we    = 1'b0;
            w_bus_sel   = c_SEL_ALL;
            w_bus_addr  = if_addr;
            w_bus_wdata = '0;
          end
        end
      end

      ARB_IF_XFER, ARB_DM_XFER: begin
        if (bus_ready) begin
          // A ready strobe wins even in the cycle that would time out.
          w_finish    = 1'b1;
          w_resp_data = bus_rdata;
        end else begin
          w_wait_cnt = r_wait_cnt + c_WAIT_W'(1);
          if (r_wait_cnt == c_TIMEOUT_LAST) begin
            w_finish    = 1'b1;
            w_resp_data = '0;
            w_bus_err   = 1'b1;
          end
        end

        if (w_finish) begin
          w_bus_req = 1'b0;
          w_state   = ARB_RESP;
          if (r_state == ARB_DM_XFER) begin
            w_dm_rdata = w_resp_data;
            w_dm_ack   = 1'b1;
          end else begin
            w_if_rdata = w_resp_data;
            w_if_ack   = 1'b1;
          end
        end
      end

      // Ack cycle: no arbitration here, so a request still held high while
      // its ack is visible cannot start a second transfer.
      ARB_RESP: w_state = ARB_IDLE;

      default:  w_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_IF;
      r_wait_cnt   <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_sel    <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_wait_cnt   <= w_wait_cnt;
      r_bus_req    <= w_bus_req;
      r_bus_we     <= w_bus_we;
      r_bus_sel    <= w_bus_sel;
      r_bus_addr   <= w_bus_addr;
      r_bus_wdata  <= w_bus_wdata;
      r_if_rdata   <= w_if_rdata;
      r_dm_rdata   <= w_dm_rdata;
      r_if_ack     <= w_if_ack;
      r_dm_ack     <= w_dm_ack;
      r_bus_err    <= w_bus_err;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_sel   = r_bus_sel;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ack    = r_dm_ack;
  assign bus_err   = r_bus_err;

  // Stall drops in the ack cycle so the pipeline advances with the data.
  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = dm_req & ~r_dm_ack;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed, table-driven bench for bus_arbiter. Each record
//               gives the inputs for one clock cycle and the outputs expected
//               just after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_sel;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_sel    (dm_sel),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_sel   (bus_sel),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_err   (bus_err)
  );

  typedef struct {
    // inputs
    logic        rst, if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr, dm_wdata, bus_rdata;
    logic        bus_ready;
    // full = compare every registered output (reset rows)
    logic        full;
    // expected outputs after the edge
    logic        e_bus_req, e_bus_we;
    logic [3:0]  e_bus_sel;
    logic [31:0] e_bus_addr, e_bus_wdata;
    logic        e_if_ack;
    logic [31:0] e_if_rdata;
    logic        e_dm_ack;
    logic [31:0] e_dm_rdata;
    logic        e_bus_err;
  } vec_t;

  // Inputs only; every expected output defaults to idle/zero.
  function automatic vec_t mk(input logic rst_i, input logic ifr,
                              input logic [31:0] ifa, input logic dmr,
                              input logic we, input logic [3:0] sel,
                              input logic [31:0] dma, input logic [31:0] wd,
                              input logic [31:0] rd, input logic rdy);
    vec_t v = '{default: '0};
    v.rst = rst_i;  v.if_req = ifr;  v.if_addr = ifa;
    v.dm_req = dmr; v.dm_we = we;    v.dm_sel = sel;
    v.dm_addr = dma; v.dm_wdata = wd; v.bus_rdata = rd; v.bus_ready = rdy;
    return v;
  endfunction

  function automatic vec_t xp_bus(input vec_t vi, input logic we,
                                  input logic [3:0] sel,
                                  input logic [31:0] a, input logic [31:0] wd);
    vec_t v = vi;
    v.e_bus_req = 1'b1; v.e_bus_we = we; v.e_bus_sel = sel;
    v.e_bus_addr = a;   v.e_bus_wdata = wd;
    return v;
  endfunction

  function automatic vec_t xp_if(input vec_t vi, input logic [31:0] rd);
    vec_t v = vi;
    v.e_if_ack = 1'b1; v.e_if_rdata = rd;
    return v;
  endfunction

  function automatic vec_t xp_dm(input vec_t vi, input logic [31:0] rd,
                                 input logic err);
    vec_t v = vi;
    v.e_dm_ack = 1'b1; v.e_dm_rdata = rd; v.e_bus_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h",
               name, n_vec, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst       = v.rst;
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    dm_req    = v.dm_req;
    dm_we     = v.dm_we;
    dm_sel    = v.dm_sel;
    dm_addr   = v.dm_addr;
    dm_wdata  = v.dm_wdata;
    bus_rdata = v.bus_rdata;
    bus_ready = v.bus_ready;
    @(posedge clk);
    #1;
    n_vec++;
    chk("bus_req", {31'b0, bus_req}, {31'b0, v.e_bus_req});
    chk("if_ack",  {31'b0, if_ack},  {31'b0, v.e_if_ack});
    chk("dm_ack",  {31'b0, dm_ack},  {31'b0, v.e_dm_ack});
    chk("bus_err", {31'b0, bus_err}, {31'b0, v.e_bus_err});
    chk("stall_if",  {31'b0, stall_if},  {31'b0, v.if_req & ~v.e_if_ack});
    chk("stall_mem", {31'b0, stall_mem}, {31'b0, v.dm_req & ~v.e_dm_ack});
    if (v.full || v.e_bus_req) begin
      chk("bus_we",    {31'b0, bus_we},  {31'b0, v.e_bus_we});
      chk("bus_sel",   {28'b0, bus_sel}, {28'b0, v.e_bus_sel});
      chk("bus_addr",  bus_addr,  v.e_bus_addr);
      chk("bus_wdata", bus_wdata, v.e_bus_wdata);
    end
    if (v.full || v.e_if_ack) chk("if_rdata", if_rdata, v.e_if_rdata);
    if (v.full || v.e_dm_ack) chk("dm_rdata", dm_rdata, v.e_dm_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t base;
    vec_t tbl[$];
    logic [31:0] rd;

    // ---------------- vector table ----------------
    // reset state
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.full = 1'b1;
    tbl.push_back(v); tbl.push_back(v);
    // single fetch, ready on the first bus_req cycle
    v = mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(xp_bus(v, 1'b0, 4'hF, 32'h10, 32'h0));
    v = mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h2401_0005, 1);
    tbl.push_back(xp_if(v, 32'h2401_0005));
    // request still high during the ack cycle: no second transfer
    v = mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h2401_0005, 1);
    tbl.push_back(v);
    // bus_ready while idle is ignored
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h2401_0005, 1);
    tbl.push_back(v);
    // reset, then simultaneous requests: DM write wins first
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.full = 1'b1;
    tbl.push_back(v);
    v = mk(0, 1, 32'h20, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 0, 0);
    tbl.push_back(xp_bus(v, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF));
    v = mk(0, 1, 32'h20, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 1);
    tbl.push_back(xp_dm(v, 32'h1111_1111, 1'b0));
    v = mk(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(v);
    v = mk(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(xp_bus(v, 1'b0, 4'hF, 32'h20, 32'h0));
    v = mk(0, 1, 32'h20, 0, 0, 0, 0, 0, 32'h2222_2222, 1);
    tbl.push_back(xp_if(v, 32'h2222_2222));
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i]);

    // ---------------- both ports held high: strict alternation ----------------
    for (int t = 0; t < 6; t++) begin
      rd   = 32'hC000_0000 + 32'(t);
      base = mk(0, 1, 32'hA0, 1, 0, 4'b1100, 32'hB0, 32'h77, rd, 1);
      if (t % 2 == 0) apply(xp_bus(base, 1'b0, 4'b1100, 32'hB0, 32'h77));
      else            apply(xp_bus(base, 1'b0, 4'hF,    32'hA0, 32'h0));
      if (t % 2 == 0) apply(xp_dm(base, rd, 1'b0));
      else            apply(xp_if(base, rd));
      apply(base);
    end

    // ---------------- timeout: four not-ready cycles abort ----------------
    base = mk(0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 32'hFFFF_FFFF, 0);
    for (int k = 0; k < 4; k++) apply(xp_bus(base, 1'b0, 4'hF, 32'h300, 32'h0));
    apply(xp_dm(base, 32'h0, 1'b1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // ---------------- ready exactly at the limit: normal completion ----------------
    base = mk(0, 0, 0, 1, 0, 4'hF, 32'h304, 0, 32'hFFFF_FFFF, 0);
    for (int k = 0; k < 4; k++) apply(xp_bus(base, 1'b0, 4'hF, 32'h304, 32'h0));
    v = mk(0, 0, 0, 1, 0, 4'hF, 32'h304, 0, 32'h5A5A_5A5A, 1);
    apply(xp_dm(v, 32'h5A5A_5A5A, 1'b0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // ---------------- reset mid-transfer ----------------
    base = mk(0, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
    apply(xp_bus(base, 1'b0, 4'hF, 32'h400, 32'h0));
    apply(xp_bus(base, 1'b0, 4'hF, 32'h400, 32'h0));
    v = mk(1, 1, 32'h400, 0, 0, 0, 0, 0, 32'h9999_9999, 1); v.full = 1'b1;
    apply(v);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h9999_9999, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fresh request afterwards
    v = mk(0, 1, 32'h404, 0, 0, 0, 0, 0, 0, 0);
    apply(xp_bus(v, 1'b0, 4'hF, 32'h404, 32'h0));
    v = mk(0, 1, 32'h404, 0, 0, 0, 0, 0, 32'h0000_600D, 1);
    apply(xp_if(v, 32'h0000_600D));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire
